// File: rtl/write_pkg.sv
// Shared types and constants for the Avalon pixel write master.
package write_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_GROUP,
      WRITE,
      DONE
   } wm_state_t;

   localparam int GROUP_SIZE      = 6;
   localparam int BYTES_PER_PIXEL = 4;
   localparam int FRAME_PIXELS    = 76800;
   localparam logic [3:0] BYTEENABLE = 4'b0111;

endpackage

// File: rtl/flex_counter.sv
// Generic wrapping counter: counts 0 .. rollover_val-1 on each enabled
// cycle, then returns to zero. A synchronous clear overrides counting.
module flex_counter #(
   parameter int NUM_CNT_BITS = 4
) (
   input  logic                    clk,
   input  logic                    n_rst,
   input  logic                    clear,
   input  logic                    count_enable,
   input  logic [NUM_CNT_BITS-1:0] rollover_val,
   output logic [NUM_CNT_BITS-1:0] count_out
);

   logic [NUM_CNT_BITS-1:0] count_q;
   logic [NUM_CNT_BITS-1:0] count_d;
   logic                    atTerminal;

   assign atTerminal = (count_q == (rollover_val - NUM_CNT_BITS'(1)));
   assign count_out  = count_q;

   // Next count: clear wins, otherwise step and wrap at the terminal value
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (count_enable) begin
         count_d = atTerminal ? '0 : (count_q + NUM_CNT_BITS'(1));
      end
   end

   // Count register with asynchronous active-low reset
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/avalon_write_master.sv
// Avalon-MM write master: drains one full group of pixels at a time from
// the write buffer and writes each as a 32-bit word to consecutive SDRAM
// addresses from a per-frame base, flagging group and frame completion.
module avalon_write_master
   import write_pkg::*;
#(
   parameter int GROUP_SIZE   = write_pkg::GROUP_SIZE,
   parameter int FRAME_PIXELS = write_pkg::FRAME_PIXELS,
   parameter int CNT_W        = 17,
   parameter int ADDR_W       = 32
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_address,
   input  logic              group_ready,
   input  logic [23:0]       pixel_in,
   input  logic              master_waitrequest,
   output logic              master_write,
   output logic [ADDR_W-1:0] master_address,
   output logic [31:0]       master_writedata,
   output logic [3:0]        master_byteenable,
   output logic              shift_enable_write,
   output logic              group_done,
   output logic              frame_done,
   output logic              busy
);

   localparam int BEAT_W = (GROUP_SIZE > 1) ? $clog2(GROUP_SIZE) : 1;

   wm_state_t         state_q;
   logic              write_q;
   logic [ADDR_W-1:0] address_q;
   logic [CNT_W-1:0]  pixelCount_q;
   logic              groupDone_q;
   logic              frameDone_q;

   logic              beatAccept;
   logic              lastBeat;
   logic              startAccept;
   logic [BEAT_W-1:0] beatCount;

   // A beat completes whenever the strobe is up and the slave is not stalling
   assign beatAccept  = write_q & ~master_waitrequest;
   assign lastBeat    = beatAccept && (beatCount == BEAT_W'(GROUP_SIZE - 1));
   assign startAccept = start && (state_q == IDLE);

   assign master_write       = write_q;
   assign master_address     = address_q;
   assign master_writedata   = {8'h00, pixel_in};
   assign master_byteenable  = BYTEENABLE;
   assign shift_enable_write = beatAccept;
   assign group_done         = groupDone_q;
   assign frame_done         = frameDone_q;
   assign busy               = (state_q != IDLE);

   flex_counter #(
      .NUM_CNT_BITS (BEAT_W)
   ) u_beatCounter (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (startAccept),
      .count_enable (beatAccept),
      .rollover_val (BEAT_W'(GROUP_SIZE)),
      .count_out    (beatCount)
   );

   // Frame sequencing FSM with registered strobe, address, pixel count and pulses
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q      <= IDLE;
         write_q      <= 1'b0;
         address_q    <= '0;
         pixelCount_q <= '0;
         groupDone_q  <= 1'b0;
         frameDone_q  <= 1'b0;
      end else begin
         groupDone_q <= 1'b0;
         frameDone_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  address_q    <= base_address;
                  pixelCount_q <= '0;
                  state_q      <= WAIT_GROUP;
               end
            end
            WAIT_GROUP: begin
               if (group_ready) begin
                  write_q <= 1'b1;
                  state_q <= WRITE;
               end
            end
            WRITE: begin
               if (beatAccept) begin
                  address_q    <= address_q + ADDR_W'(BYTES_PER_PIXEL);
                  pixelCount_q <= pixelCount_q + CNT_W'(1);
                  if (lastBeat) begin
                     write_q     <= 1'b0;
                     groupDone_q <= 1'b1;
                     if (pixelCount_q == CNT_W'(FRAME_PIXELS - 1)) begin
                        frameDone_q <= 1'b1;
                        state_q     <= DONE;
                     end else begin
                        state_q <= WAIT_GROUP;
                     end
                  end
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               write_q <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_avalon_write_master.sv
// Directed testbench for avalon_write_master (frame shortened to 12 pixels).
module tb_avalon_write_master;

   logic        clk;
   logic        n_rst;
   logic        start;
   logic [31:0] base_address;
   logic        group_ready;
   logic [23:0] pixel_in;
   logic        master_waitrequest;
   logic        master_write;
   logic [31:0] master_address;
   logic [31:0] master_writedata;
   logic [3:0]  master_byteenable;
   logic        shift_enable_write;
   logic        group_done;
   logic        frame_done;
   logic        busy;

   int checks = 0;
   int errors = 0;

   avalon_write_master #(
      .GROUP_SIZE   (6),
      .FRAME_PIXELS (12),
      .CNT_W        (17),
      .ADDR_W       (32)
   ) dut (
      .clk                (clk),
      .n_rst              (n_rst),
      .start              (start),
      .base_address       (base_address),
      .group_ready        (group_ready),
      .pixel_in           (pixel_in),
      .master_waitrequest (master_waitrequest),
      .master_write       (master_write),
      .master_address     (master_address),
      .master_writedata   (master_writedata),
      .master_byteenable  (master_byteenable),
      .shift_enable_write (shift_enable_write),
      .group_done         (group_done),
      .frame_done         (frame_done),
      .busy               (busy)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Hold reset for two cycles with all inputs idle, release on a falling edge
   task automatic doReset();
      n_rst = 1'b0;
      start = 1'b0;
      base_address = 32'h0;
      group_ready = 1'b0;
      master_waitrequest = 1'b0;
      pixel_in = 24'h123456;
      repeat (2) @(negedge clk);
      n_rst = 1'b1;
   endtask

   // One-cycle start pulse; returns at the falling edge of the following cycle
   task automatic applyStimulus(input logic [31:0] base);
      @(negedge clk);
      start = 1'b1;
      base_address = base;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Output values while reset is held
   task automatic test_reset();
      n_rst = 1'b0;
      start = 1'b0;
      base_address = 32'hDEAD_BEEF;
      group_ready = 1'b1;
      master_waitrequest = 1'b0;
      pixel_in = 24'h123456;
      #12;
      checks++;
      if (master_write !== 1'b0 || shift_enable_write !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_strobes: write=%b shift=%b expected 0 0", master_write, shift_enable_write);
      end
      checks++;
      if (master_address !== 32'h0) begin
         errors++;
         $display("[TB] FAIL reset_address: got %h expected 00000000", master_address);
      end
      checks++;
      if (group_done !== 1'b0 || frame_done !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags: gd=%b fd=%b busy=%b expected 0 0 0", group_done, frame_done, busy);
      end
      checks++;
      if (master_byteenable !== 4'b0111 || master_writedata !== 32'h0012_3456) begin
         errors++;
         $display("[TB] FAIL reset_data: be=%b wd=%h expected 0111 00123456", master_byteenable, master_writedata);
      end
   endtask

   // One zero-wait group: latency, address sequence, pops and group_done
   task automatic test_basic_group();
      logic [23:0] pix;
      int          shifts;
      doReset();
      group_ready = 1'b1;
      shifts = 0;
      applyStimulus(32'h0010_0000);
      #1;
      checks++;
      if (master_write !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL basic_wait_cycle: write=%b busy=%b expected 0 1", master_write, busy);
      end
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         pix = 24'hA0_0000 + 24'(k);
         pixel_in = pix;
         #1;
         if (shift_enable_write === 1'b1) shifts++;
         checks++;
         if (master_write !== 1'b1 || shift_enable_write !== 1'b1 || group_done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_beat%0d_strobes: write=%b shift=%b gd=%b expected 1 1 0", k, master_write, shift_enable_write, group_done);
         end
         checks++;
         if (master_address !== (32'h0010_0000 + 32'(4 * k)) || master_writedata !== {8'h00, pix}) begin
            errors++;
            $display("[TB] FAIL basic_beat%0d_bus: addr=%h wd=%h expected %h %h", k, master_address, master_writedata, 32'h0010_0000 + 32'(4 * k), {8'h00, pix});
         end
      end
      @(negedge clk);
      #1;
      checks++;
      if (group_done !== 1'b1 || frame_done !== 1'b0 || master_write !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL basic_group_done: gd=%b fd=%b write=%b busy=%b expected 1 0 0 1", group_done, frame_done, master_write, busy);
      end
      checks++;
      if (shifts != 6) begin
         errors++;
         $display("[TB] FAIL basic_shift_count: got %0d expected 6", shifts);
      end
   endtask

   // Three-cycle stall on beat 2: bus held stable, no pop until acceptance
   task automatic test_waitrequest();
      int waitV[9]  = '{0, 0, 1, 1, 1, 0, 0, 0, 0};
      int offV[9]   = '{0, 4, 8, 8, 8, 8, 12, 16, 20};
      int shiftV[9] = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
      logic [23:0] pix;
      int          shifts;
      doReset();
      group_ready = 1'b1;
      shifts = 0;
      applyStimulus(32'h0010_0000);
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         master_waitrequest = (waitV[c] != 0);
         pix = 24'hC0_0000 + 24'(offV[c]);
         pixel_in = pix;
         #1;
         if (shift_enable_write === 1'b1) shifts++;
         checks++;
         if (master_write !== 1'b1 || shift_enable_write !== (shiftV[c] != 0)) begin
            errors++;
            $display("[TB] FAIL wait_cycle%0d_strobes: write=%b shift=%b expected 1 %0d", c, master_write, shift_enable_write, shiftV[c]);
         end
         checks++;
         if (master_address !== (32'h0010_0000 + 32'(offV[c])) || master_writedata !== {8'h00, pix}) begin
            errors++;
            $display("[TB] FAIL wait_cycle%0d_bus: addr=%h wd=%h expected %h %h", c, master_address, master_writedata, 32'h0010_0000 + 32'(offV[c]), {8'h00, pix});
         end
      end
      master_waitrequest = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if (group_done !== 1'b1 || master_write !== 1'b0) begin
         errors++;
         $display("[TB] FAIL wait_group_done: gd=%b write=%b expected 1 0", group_done, master_write);
      end
      checks++;
      if (shifts != 6) begin
         errors++;
         $display("[TB] FAIL wait_beat_total: got %0d expected 6", shifts);
      end
   endtask

   // Whole 12-pixel frame with group_ready held high
   task automatic test_full_frame();
      int beats, gdCount, fdCount, fdWithGd, fdCycle, busyAfter;
      logic prevFd;
      doReset();
      group_ready = 1'b1;
      beats = 0; gdCount = 0; fdCount = 0; fdWithGd = 0; fdCycle = -1; busyAfter = -1;
      prevFd = 1'b0;
      applyStimulus(32'h0000_1000);
      for (int c = 1; c <= 20; c++) begin
         #1;
         if (shift_enable_write === 1'b1) beats++;
         if (group_done === 1'b1) gdCount++;
         if (prevFd) busyAfter = int'(busy);
         if (frame_done === 1'b1) begin
            fdCount++;
            fdCycle = c;
            if (group_done === 1'b1) fdWithGd++;
         end
         prevFd = (frame_done === 1'b1);
         @(negedge clk);
      end
      checks++;
      if (beats != 12) begin
         errors++;
         $display("[TB] FAIL frame_beats: got %0d expected 12", beats);
      end
      checks++;
      if (gdCount != 2) begin
         errors++;
         $display("[TB] FAIL frame_group_done_count: got %0d expected 2", gdCount);
      end
      checks++;
      if (fdCount != 1 || fdWithGd != 1) begin
         errors++;
         $display("[TB] FAIL frame_done_pulse: count=%0d withGd=%0d expected 1 1", fdCount, fdWithGd);
      end
      checks++;
      if (fdCycle != 15) begin
         errors++;
         $display("[TB] FAIL frame_done_cycle: got %0d expected 15", fdCycle);
      end
      checks++;
      if (busyAfter != 0) begin
         errors++;
         $display("[TB] FAIL frame_busy_after: got %0d expected 0", busyAfter);
      end
   endtask

   // A start pulse during WRITE must not disturb the running frame
   task automatic test_ignored_start();
      int beats;
      doReset();
      group_ready = 1'b1;
      beats = 0;
      applyStimulus(32'h0010_0000);
      for (int c = 1; c <= 20; c++) begin
         if (c == 4) begin
            start = 1'b1;
            base_address = 32'h0020_0000;
         end else begin
            start = 1'b0;
         end
         #1;
         if (shift_enable_write === 1'b1) begin
            checks++;
            if (master_address !== (32'h0010_0000 + 32'(4 * beats))) begin
               errors++;
               $display("[TB] FAIL ignore_addr_beat%0d: got %h expected %h", beats, master_address, 32'h0010_0000 + 32'(4 * beats));
            end
            beats++;
         end
         @(negedge clk);
      end
      checks++;
      if (beats != 12 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ignore_frame_end: beats=%0d busy=%b expected 12 0", beats, busy);
      end
   endtask

   // Reset mid-stall clears outputs at once; next start uses the new base
   task automatic test_reset_mid();
      doReset();
      group_ready = 1'b1;
      applyStimulus(32'h0010_0000);
      @(negedge clk);
      @(negedge clk);
      master_waitrequest = 1'b1;
      #1;
      checks++;
      if (master_write !== 1'b1 || master_address !== 32'h0010_0004) begin
         errors++;
         $display("[TB] FAIL rstmid_pre: write=%b addr=%h expected 1 00100004", master_write, master_address);
      end
      #1;
      n_rst = 1'b0;
      #1;
      checks++;
      if (master_write !== 1'b0 || shift_enable_write !== 1'b0 || master_address !== 32'h0) begin
         errors++;
         $display("[TB] FAIL rstmid_bus: write=%b shift=%b addr=%h expected 0 0 00000000", master_write, shift_enable_write, master_address);
      end
      checks++;
      if (busy !== 1'b0 || group_done !== 1'b0 || frame_done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL rstmid_flags: busy=%b gd=%b fd=%b expected 0 0 0", busy, group_done, frame_done);
      end
      @(negedge clk);
      n_rst = 1'b1;
      master_waitrequest = 1'b0;
      applyStimulus(32'h0030_0000);
      #1;
      checks++;
      if (master_write !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rstmid_restart_wait: write=%b busy=%b expected 0 1", master_write, busy);
      end
      @(negedge clk);
      #1;
      checks++;
      if (master_write !== 1'b1 || master_address !== 32'h0030_0000) begin
         errors++;
         $display("[TB] FAIL rstmid_restart_addr: write=%b addr=%h expected 1 00300000", master_write, master_address);
      end
   endtask

   // group_ready low for 10 cycles after group 1 parks the FSM in WAIT_GROUP
   task automatic test_group_gap();
      int stray;
      doReset();
      group_ready = 1'b1;
      stray = 0;
      applyStimulus(32'h0040_0000);
      repeat (6) @(negedge clk);
      @(negedge clk);
      group_ready = 1'b0;
      #1;
      checks++;
      if (group_done !== 1'b1 || master_write !== 1'b0) begin
         errors++;
         $display("[TB] FAIL gap_group_done: gd=%b write=%b expected 1 0", group_done, master_write);
      end
      for (int i = 1; i < 10; i++) begin
         @(negedge clk);
         #1;
         if (master_write !== 1'b0 || shift_enable_write !== 1'b0 || busy !== 1'b1) stray++;
      end
      checks++;
      if (stray != 0) begin
         errors++;
         $display("[TB] FAIL gap_idle_cycles: bad cycles %0d expected 0", stray);
      end
      @(negedge clk);
      group_ready = 1'b1;
      #1;
      checks++;
      if (master_write !== 1'b0) begin
         errors++;
         $display("[TB] FAIL gap_rise_cycle: write=%b expected 0", master_write);
      end
      @(negedge clk);
      #1;
      checks++;
      if (master_write !== 1'b1 || master_address !== 32'h0040_0018) begin
         errors++;
         $display("[TB] FAIL gap_resume: write=%b addr=%h expected 1 00400018", master_write, master_address);
      end
   endtask

   // Run every scenario in order, then report
   initial begin
      test_reset();
      test_basic_group();
      test_waitrequest();
      test_full_frame();
      test_ignored_start();
      test_reset_mid();
      test_group_gap();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
